// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared constants and types for the frame-buffer write side.
//   H_PIXELS / V_PIXELS : frame geometry (pixels per line, lines per frame)
//   FB_DEPTH            : number of stored pixels (H_PIXELS * V_PIXELS)
//   ADDR_WIDTH          : BRAM address width, 2^ADDR_WIDTH >= FB_DEPTH
//   COLOR_DEPTH         : width of one stored pixel
//   WB_DELAY            : cycles from read-address update to the IIR result
//   fb_state_t          : write-controller FSM states
//   addr_t              : frame-buffer address
// ---------------------------------------------------------------------------
package fb_pkg;

  localparam int H_PIXELS    = 320;
  localparam int V_PIXELS    = 240;
  localparam int FB_DEPTH    = H_PIXELS * V_PIXELS;
  localparam int ADDR_WIDTH  = 17;
  localparam int COLOR_DEPTH = 12;
  localparam int WB_DELAY    = 3;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  // IDLE   : normal IIR write-back
  // ARMED  : clear requested, waiting for the next frame start
  // SWEEP  : writing zeros to every address, one per cycle
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SWEEP = 2'd2
  } fb_state_t;

endpackage

// File: rtl/fb_addr_delay.sv
// ---------------------------------------------------------------------------
// fb_addr_delay
// Fixed-depth shift register carrying {address, tag} pairs. It advances on
// every clock so the tail always holds the entry that entered DEPTH cycles
// earlier, independent of any valid qualifier.
// Ports:
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset, clears every stage
//   addr_i  : address entering stage 0
//   tag_i   : tag travelling with addr_i
//   addr_o  : address leaving the last stage
//   tag_o   : tag leaving the last stage
// ---------------------------------------------------------------------------
module fb_addr_delay #(
  parameter int ADDR_WIDTH = 17,
  parameter int DEPTH      = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  tag_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  tag_o
);

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic                  tag_q  [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        tag_q[i]  <= 1'b0;
      end
    end else begin
      addr_q[0] <= addr_i;
      tag_q[0]  <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        addr_q[i] <= addr_q[i-1];
        tag_q[i]  <= tag_q[i-1];
      end
    end
  end

  assign addr_o = addr_q[DEPTH-1];
  assign tag_o  = tag_q[DEPTH-1];

endmodule

// File: rtl/fb_write_ctrl.sv
// ---------------------------------------------------------------------------
// fb_write_ctrl
// Write-side controller between the trail IIR stage and the two frame-buffer
// BRAMs (IIR history and display), all in the camera clock domain.
//   - Turns camera (hcount, vcount) into a linear history read address.
//   - Delays that address so it lines up with the IIR result and drives the
//     shared write port.
//   - On request, zeroes the whole buffer with a sweep that starts on the
//     next frame boundary.
// Ports:
//   clk_in         : camera clock
//   rst_in         : asynchronous active-high reset
//   valid_in       : camera coordinate valid
//   hcount_in      : camera column
//   vcount_in      : camera row
//   iir_valid_in   : IIR result valid
//   iir_data_in    : IIR updated pixel
//   clear_in       : single-cycle clear request
//   frame_start_in : single-cycle pulse on the first pixel of a frame
//   rd_addr_out    : history-port read address (1 cycle after valid_in)
//   wr_addr_out    : write address to both BRAMs
//   wr_data_out    : write data
//   wr_en_out      : write enable
//   busy_out       : clear armed or sweeping
//   oob_count_out  : saturating count of out-of-range coordinates
//
// Write port handshake: the write port has no back-pressure. A write happens
// in every cycle where wr_en_out=1, using wr_addr_out/wr_data_out of that
// same cycle; the BRAMs must accept it unconditionally.
// ---------------------------------------------------------------------------
module fb_write_ctrl
  import fb_pkg::*;
#(
  parameter int H_PIXELS    = fb_pkg::H_PIXELS,
  parameter int V_PIXELS    = fb_pkg::V_PIXELS,
  parameter int COLOR_DEPTH = fb_pkg::COLOR_DEPTH,
  parameter int ADDR_WIDTH  = fb_pkg::ADDR_WIDTH,
  parameter int WB_DELAY    = fb_pkg::WB_DELAY
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   valid_in,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   iir_valid_in,
  input  logic [COLOR_DEPTH-1:0] iir_data_in,
  input  logic                   clear_in,
  input  logic                   frame_start_in,
  output logic [ADDR_WIDTH-1:0]  rd_addr_out,
  output logic [ADDR_WIDTH-1:0]  wr_addr_out,
  output logic [COLOR_DEPTH-1:0] wr_data_out,
  output logic                   wr_en_out,
  output logic                   busy_out,
  output logic [7:0]             oob_count_out
);

  // One bit of headroom for the linear address sum before truncation.
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(H_PIXELS * V_PIXELS - 1);

  // -------------------------------------------------------------------------
  // Read address and out-of-range tracking
  // -------------------------------------------------------------------------
  logic [AW1-1:0]        lin_w;
  logic                  oob_w;

  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_oob_q,  rd_oob_d;
  logic [7:0]            oob_cnt_q, oob_cnt_d;

  assign lin_w = AW1'(hcount_in) + AW1'(H_PIXELS) * AW1'(vcount_in);
  assign oob_w = (32'(hcount_in) >= H_PIXELS) || (32'(vcount_in) >= V_PIXELS);

  // Out-of-range coordinates still produce an address; the tag travels with
  // it so the matching IIR result is suppressed at the write port.
  always_comb begin
    rd_addr_d = rd_addr_q;
    rd_oob_d  = rd_oob_q;
    oob_cnt_d = oob_cnt_q;
    if (valid_in) begin
      rd_addr_d = lin_w[ADDR_WIDTH-1:0];
      rd_oob_d  = oob_w;
      if (oob_w && (oob_cnt_q != 8'hFF)) begin
        oob_cnt_d = oob_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_addr_q <= '0;
      rd_oob_q  <= 1'b0;
      oob_cnt_q <= '0;
    end else begin
      rd_addr_q <= rd_addr_d;
      rd_oob_q  <= rd_oob_d;
      oob_cnt_q <= oob_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Delay line: the registered read address (and its tag) is shifted so that
  // its tail reaches the write mux in the same cycle as the IIR result.
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] tail_addr;
  logic                  tail_oob;

  fb_addr_delay #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (WB_DELAY)
  ) u_addr_delay (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .addr_i (rd_addr_q),
    .tag_i  (rd_oob_q),
    .addr_o (tail_addr),
    .tag_o  (tail_oob)
  );

  // -------------------------------------------------------------------------
  // Clear FSM and registered write mux
  // -------------------------------------------------------------------------
  fb_state_t             state_q,     state_d;
  logic [ADDR_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;
  logic                  wr_en_q,     wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q,   wr_addr_d;
  logic [COLOR_DEPTH-1:0] wr_data_q,  wr_data_d;
  logic                  start_sweep;

  // A sweep begins on a frame start once a clear is pending; a clear arriving
  // together with the frame start skips ARMED entirely.
  assign start_sweep = frame_start_in &&
                       ((state_q == ARMED) || ((state_q == IDLE) && clear_in));

  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    // Default: IIR write-back of the aligned tail address.
    wr_en_d     = iir_valid_in & ~tail_oob;
    wr_addr_d   = tail_addr;
    wr_data_d   = iir_data_in;

    unique case (state_q)
      IDLE: begin
        if (clear_in && !frame_start_in) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        // A repeated clear_in is irrelevant here: already armed.
      end
      SWEEP: begin
        // IIR results are dropped for the whole sweep; clear_in and
        // frame_start_in are ignored so a sweep is never restarted.
        wr_data_d = '0;
        if (sweep_cnt_q == LAST_ADDR) begin
          state_d     = IDLE;
          sweep_cnt_d = '0;
          wr_en_d     = 1'b0;
          wr_addr_d   = '0;
        end else begin
          sweep_cnt_d = sweep_cnt_q + 1'b1;
          wr_en_d     = 1'b1;
          wr_addr_d   = sweep_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Address 0 goes out on the edge that enters SWEEP, so the first clear
    // write is visible in the first SWEEP cycle.
    if (start_sweep) begin
      state_d     = SWEEP;
      sweep_cnt_d = '0;
      wr_en_d     = 1'b1;
      wr_addr_d   = '0;
      wr_data_d   = '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      sweep_cnt_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign rd_addr_out   = rd_addr_q;
  assign wr_addr_out   = wr_addr_q;
  assign wr_data_out   = wr_data_q;
  assign wr_en_out     = wr_en_q;
  assign busy_out      = (state_q != IDLE);
  assign oob_count_out = oob_cnt_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fb_write_ctrl
// Directed bench for fb_write_ctrl. A behavioural model derives every output
// from the frame geometry, the write-back delay and the clear rules; a
// compare process checks it against the DUT on each falling edge, and the
// directed sequence adds hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_fb_write_ctrl;

  localparam int H        = 320;
  localparam int V        = 240;
  localparam int DEPTH    = H * V;
  localparam int AW       = 17;
  localparam int CD       = 12;
  localparam int WBD      = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          valid_in;
  logic [10:0]   hcount_in;
  logic [9:0]    vcount_in;
  logic          iir_valid_in;
  logic [CD-1:0] iir_data_in;
  logic          clear_in;
  logic          frame_start_in;
  logic [AW-1:0] rd_addr_out;
  logic [AW-1:0] wr_addr_out;
  logic [CD-1:0] wr_data_out;
  logic          wr_en_out;
  logic          busy_out;
  logic [7:0]    oob_count_out;

  fb_write_ctrl dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .valid_in       (valid_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .iir_valid_in   (iir_valid_in),
    .iir_data_in    (iir_data_in),
    .clear_in       (clear_in),
    .frame_start_in (frame_start_in),
    .rd_addr_out    (rd_addr_out),
    .wr_addr_out    (wr_addr_out),
    .wr_data_out    (wr_data_out),
    .wr_en_out      (wr_en_out),
    .busy_out       (busy_out),
    .oob_count_out  (oob_count_out)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Read side: address = (h + H*v) mod 2^AW, tagged out-of-range when the
  // coordinate lies outside the frame. The pairing rule is "the read address
  // seen WBD cycles ago meets this cycle's IIR result", kept as a queue of
  // past read-address values (exp_q/tag_q, oldest first).
  // Clear side: a sweep is a window of DEPTH cycles starting at sweep_start;
  // inside it the expected write address is just the cycle offset.
  logic [AW-1:0] exp_q[$];
  bit            tag_q[$];
  longint        cyc_n = 0;
  longint        sweep_start = -1;
  bit            armed;
  int            m_rd;
  bit            m_rd_oob;
  int            m_oob_cnt;
  bit            e_wen;
  int            e_waddr;
  int            e_wdata;

  function automatic bit in_sweep(input longint t);
    return (sweep_start >= 0) && (t >= sweep_start) && (t - sweep_start < DEPTH);
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [AW-1:0] t_addr;
    bit            t_oob;
    bit            was_sweep;
    int            lin;
    bit            oob;
    if (rst) begin
      sweep_start = -1;
      armed       = 1'b0;
      m_rd        = 0;
      m_rd_oob    = 1'b0;
      m_oob_cnt   = 0;
      e_wen       = 1'b0;
      e_waddr     = 0;
      e_wdata     = 0;
      exp_q.delete();
      tag_q.delete();
      for (int i = 0; i < WBD; i++) begin
        exp_q.push_back('0);
        tag_q.push_back(1'b0);
      end
    end else begin
      was_sweep = in_sweep(cyc_n);
      t_addr = exp_q.pop_front();
      t_oob  = tag_q.pop_front();
      exp_q.push_back(AW'(m_rd));
      tag_q.push_back(m_rd_oob);
      if (valid_in) begin
        lin      = (int'(hcount_in) + H * int'(vcount_in)) % (1 << AW);
        oob      = (int'(hcount_in) >= H) || (int'(vcount_in) >= V);
        m_rd     = lin;
        m_rd_oob = oob;
        if (oob && m_oob_cnt < 255) m_oob_cnt++;
      end
      if (!was_sweep && frame_start_in && (armed || clear_in)) begin
        sweep_start = cyc_n + 1;
        armed       = 1'b0;
      end else if (!was_sweep && clear_in) begin
        armed = 1'b1;
      end
      cyc_n++;
      if (in_sweep(cyc_n)) begin
        e_wen   = 1'b1;
        e_waddr = int'(cyc_n - sweep_start);
        e_wdata = 0;
      end else if (was_sweep) begin
        e_wen = 1'b0;
      end else begin
        e_wen   = iir_valid_in && !t_oob;
        e_waddr = int'(t_addr);
        e_wdata = int'(iir_data_in);
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("rd_addr", 32'(rd_addr_out), m_rd);
      chk("oob_count", 32'(oob_count_out), m_oob_cnt);
      chk("busy", 32'(busy_out), 32'(armed || in_sweep(cyc_n)));
      chk("wr_en", 32'(wr_en_out), 32'(e_wen));
      if (e_wen) begin
        chk("wr_addr", 32'(wr_addr_out), e_waddr);
        chk("wr_data", 32'(wr_data_out), e_wdata);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Coordinate -> read address -> matching IIR result -> write.
  task automatic do_write(input int h, input int v, input int data, input int exp_addr);
    valid_in  = 1'b1;
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    cyc(1);
    valid_in = 1'b0;
    @(negedge clk);
    chk("lit_rd_addr", 32'(rd_addr_out), exp_addr);
    cyc(3);
    iir_valid_in = 1'b1;
    iir_data_in  = CD'(data);
    cyc(1);
    iir_valid_in = 1'b0;
    @(negedge clk);
    chk("lit_wr_en", 32'(wr_en_out), 1);
    chk("lit_wr_addr", 32'(wr_addr_out), exp_addr);
    chk("lit_wr_data", 32'(wr_data_out), data);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int  n_wr;
    int  last_addr;
    bit  done;

    valid_in       = 1'b0;
    hcount_in      = '0;
    vcount_in      = '0;
    iir_valid_in   = 1'b0;
    iir_data_in    = '0;
    clear_in       = 1'b0;
    frame_start_in = 1'b0;
    rst            = 1'b1;

    // 1. reset values
    @(negedge clk);
    chk("rst_rd_addr", 32'(rd_addr_out), 0);
    chk("rst_wr_addr", 32'(wr_addr_out), 0);
    chk("rst_wr_data", 32'(wr_data_out), 0);
    chk("rst_wr_en", 32'(wr_en_out), 0);
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_oob", 32'(oob_count_out), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 2. basic write-back: (5,2) -> 645
    do_write(5, 2, 'hABC, 645);

    // asynchronous reset between clock edges
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rd_addr", 32'(rd_addr_out), 0);
    chk("async_wr_addr", 32'(wr_addr_out), 0);
    chk("async_wr_data", 32'(wr_data_out), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // last in-range pixel
    do_write(319, 239, 'h5A5, 76799);

    // 3. out-of-range coordinates never write
    valid_in  = 1'b1;
    hcount_in = 11'd320;
    vcount_in = 10'd0;
    cyc(1);
    hcount_in = 11'd0;
    vcount_in = 10'd240;
    cyc(1);
    valid_in = 1'b0;
    cyc(2);
    iir_valid_in = 1'b1;
    iir_data_in  = 12'h777;
    cyc(1);
    @(negedge clk);
    chk("oob_wr_en_a", 32'(wr_en_out), 0);
    cyc(1);
    iir_valid_in = 1'b0;
    @(negedge clk);
    chk("oob_wr_en_b", 32'(wr_en_out), 0);
    chk("oob_count_2", 32'(oob_count_out), 2);

    // address wrap: 1023 + 320*1023 = 328383 mod 2^17 = 66239
    valid_in  = 1'b1;
    hcount_in = 11'd1023;
    vcount_in = 10'd1023;
    cyc(1);
    valid_in = 1'b0;
    @(negedge clk);
    chk("wrap_rd_addr", 32'(rd_addr_out), 66239);
    chk("oob_count_3", 32'(oob_count_out), 3);

    // saturation
    valid_in  = 1'b1;
    hcount_in = 11'd400;
    vcount_in = 10'd0;
    cyc(300);
    valid_in = 1'b0;
    @(negedge clk);
    chk("oob_count_sat", 32'(oob_count_out), 255);

    // 4 + 6. armed clear, sweep start on frame_start, reset mid-sweep
    cyc(1);
    clear_in = 1'b1;
    cyc(1);
    clear_in = 1'b0;
    @(negedge clk);
    chk("armed_busy", 32'(busy_out), 1);
    chk("armed_wr_en", 32'(wr_en_out), 0);
    cyc(4);
    iir_valid_in = 1'b1;
    iir_data_in  = 12'hFFF;
    cyc(5);
    frame_start_in = 1'b1;
    cyc(1);
    frame_start_in = 1'b0;
    @(negedge clk);
    chk("sweep0_wr_en", 32'(wr_en_out), 1);
    chk("sweep0_wr_addr", 32'(wr_addr_out), 0);
    chk("sweep0_wr_data", 32'(wr_data_out), 0);
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (wr_addr_out == AW'(1000)) done = 1'b1;
    end
    chk("reach_addr_1000", 32'(done), 1);
    #1 rst = 1'b1;
    iir_valid_in = 1'b0;
    #1;
    chk("abort_wr_en", 32'(wr_en_out), 0);
    chk("abort_busy", 32'(busy_out), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    do_write(5, 2, 'h123, 645);

    // 5. same-cycle clear + frame_start, second clear mid-sweep, full length
    clear_in       = 1'b1;
    frame_start_in = 1'b1;
    iir_valid_in   = 1'b1;
    iir_data_in    = 12'hFFF;
    cyc(1);
    clear_in       = 1'b0;
    frame_start_in = 1'b0;
    @(negedge clk);
    chk("fast_wr_en", 32'(wr_en_out), 1);
    chk("fast_wr_addr", 32'(wr_addr_out), 0);
    chk("fast_busy", 32'(busy_out), 1);
    n_wr      = 0;
    last_addr = -1;
    done      = 1'b0;
    for (int i = 0; i < 80000 && !done; i++) begin
      if (!busy_out) begin
        done = 1'b1;
      end else begin
        if (wr_en_out && wr_data_out == '0) begin
          n_wr++;
          last_addr = int'(wr_addr_out);
        end
        if (i == 40000) begin
          clear_in       = 1'b1;
          frame_start_in = 1'b1;
        end else begin
          clear_in       = 1'b0;
          frame_start_in = 1'b0;
        end
        @(negedge clk);
      end
    end
    iir_valid_in = 1'b0;
    chk("sweep_done", 32'(done), 1);
    chk("sweep_writes", 32'(n_wr), 76800);
    chk("sweep_last_addr", 32'(last_addr), 76799);
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_write_ctrl.md
Name: fb_write_ctrl

Overview:
Write-side controller between the trail IIR stage and the two frame-buffer BRAMs (IIR history and display), all on the camera clock.
- Converts camera (hcount, vcount) into a linear read address for the history port.
- Delays that address to line up with the IIR result and drives the shared write port.
- Adds a frame-synchronous clear sweep that zeroes the whole buffer on request.

Parameters:
H_PIXELS, 320, pixels per line.
V_PIXELS, 240, lines per frame.
COLOR_DEPTH, 12, width of one stored pixel.
ADDR_WIDTH, 17, address width; must satisfy 2^ADDR_WIDTH >= H_PIXELS*V_PIXELS.
WB_DELAY, 3, cycles from rd_addr_out update to the matching iir_valid_in; minimum 1.

Ports:
clk_in  input  1  camera clock.
rst_in  input  1  asynchronous, active-high reset.
valid_in  input  1  camera coordinate valid.
hcount_in  input  11  camera column.
vcount_in  input  10  camera row.
iir_valid_in  input  1  IIR result valid.
iir_data_in  input  COLOR_DEPTH  IIR updated pixel.
clear_in  input  1  single-cycle clear request.
frame_start_in  input  1  single-cycle pulse on the first pixel of a frame.
rd_addr_out  output  ADDR_WIDTH  history-port read address.
wr_addr_out  output  ADDR_WIDTH  write address to both BRAMs.
wr_data_out  output  COLOR_DEPTH  write data.
wr_en_out  output  1  write enable.
busy_out  output  1  clear armed or sweeping.
oob_count_out  output  8  saturating count of out-of-range coordinates.

Behaviour:
Reset
- All outputs go to 0 asynchronously; FSM enters IDLE; delay line is cleared.

Read address (latency 1)
- On a cycle with valid_in=1: rd_addr_out <= hcount_in + H_PIXELS*vcount_in on the next edge.
- Otherwise rd_addr_out holds its value.
- A coordinate is out of range when hcount_in >= H_PIXELS or vcount_in >= V_PIXELS.
  - rd_addr_out still updates.
  - An out-of-range tag enters the delay line with that address.
  - oob_count_out increments, saturating at 255.

Delay line
- Shift register of depth WB_DELAY holding {addr, oob tag}, advanced every cycle.
- The tail entry is paired with iir_valid_in in the same cycle.

Write port (registered, latency 1 from iir_valid_in)
- In IDLE or ARMED, on the next edge:
  - wr_en_out <= iir_valid_in & ~tail_oob
  - wr_addr_out <= tail_addr
  - wr_data_out <= iir_data_in
- In SWEEP: IIR writes are dropped silently and wr_en_out=1 every cycle with wr_data_out=0.

FSM
- IDLE: clear_in -> ARMED.
- ARMED: busy_out=1; wait for frame_start_in -> SWEEP with sweep counter = 0.
  - If clear_in and frame_start_in arrive in the same cycle in IDLE, go directly to SWEEP.
- SWEEP: busy_out=1; wr_addr_out = counter; counter increments each cycle.
  - After address H_PIXELS*V_PIXELS-1 is written, go to IDLE.
  - Sweep duration is exactly 76800 cycles.
- clear_in while in ARMED or SWEEP is ignored (no restart).
- frame_start_in during SWEEP is ignored.
- Reset mid-sweep aborts immediately to IDLE; partially cleared contents stay as they are.

Width and wrap rules
- Address arithmetic is done at ADDR_WIDTH+1 bits and then truncated.
- The sweep counter never wraps; termination is by compare, not overflow.

Decomposition:
- Package fb_pkg:
  - H_PIXELS, V_PIXELS, FB_DEPTH = H_PIXELS*V_PIXELS
  - ADDR_WIDTH
  - fb_state_t enum {IDLE, ARMED, SWEEP}
  - addr_t typedef
- One sub-module: fb_addr_delay, a parameterised {addr, tag} shift register of depth WB_DELAY with async reset.
- The FSM and write mux stay in the top of the block.

Test Plan:
1. Reset with all inputs 0 -> every output reads 0 and busy_out=0; assert rst_in mid-cycle -> outputs clear without waiting for a clock edge.
2. valid_in with (h=5, v=2) -> rd_addr_out=645 one cycle later; iir_valid_in WB_DELAY cycles after rd_addr_out updates, with data 0xABC -> next cycle wr_en_out=1, wr_addr_out=645, wr_data_out=0xABC.
3. Coordinates (h=320, v=0) and then (h=0, v=240), followed by matching iir_valid_in -> wr_en_out stays 0 and oob_count_out=2; 300 out-of-range coordinates -> oob_count_out=255.
4. clear_in, then frame_start_in 10 cycles later -> busy_out high from the cycle after clear_in; 76800 consecutive writes of 0 to addresses 0..76799; busy_out=0 the cycle after the last write; a concurrent iir_valid_in is never written.
5. clear_in and frame_start_in in the same cycle -> the sweep starts next cycle at address 0; a second clear_in mid-sweep -> sweep length is still 76800.
6. rst_in asserted at sweep address 1000 -> wr_en_out=0 immediately, FSM in IDLE; a following normal IIR write to address 645 succeeds.
